// File: rtl/axist_patgen_pkg.sv
// Shared types and default widths for the AXIST pattern-generator run sequencer.
package axist_patgen_pkg;

  localparam int SEED_W_DEF = 40;
  localparam int NB_W_DEF   = 8;
  localparam int GAP_W_DEF  = 4;
  localparam int TMO_W_DEF  = 12;
  localparam int TOT_W_DEF  = 16;
  localparam int LEN_W      = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    GAP,
    DONE
  } state_t;

  // Stall count at which the run is declared hung.
  function automatic int tmo_limit(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/axist_patgen_ctrl_if.sv
// Controller <-> generator handshake: seeded enable pulse out, per-beat advance back.
interface axist_patgen_ctrl_if
  import axist_patgen_pkg::*;
#(
  parameter int SEED_W = SEED_W_DEF
);
  logic              gen_ena;
  logic [SEED_W-1:0] gen_seed;
  logic [LEN_W-1:0]  gen_cnt;
  logic              gen_beat;

  modport master (output gen_ena, gen_seed, gen_cnt, input gen_beat);
  modport slave  (input gen_ena, gen_seed, gen_cnt, output gen_beat);
endinterface

// File: rtl/axist_patgen_stall_tmr.sv
// Stall timer: clear wins over increment; tc_o flags the increment that reaches the limit.
module axist_patgen_stall_tmr
  import axist_patgen_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);
  localparam logic [TMO_W-1:0] TC_AT = TMO_W'(tmo_limit(TMO_W) - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = inc_i && !clr_i && (cnt_q == TC_AT);

endmodule

// File: rtl/axist_patgen_ctrl.sv
// Run-level sequencer: schedules N seeded bursts through the generator with idle gaps,
// counts accepted beats, and reports done / timeout / abort status. All outputs registered.
module axist_patgen_ctrl
  import axist_patgen_pkg::*;
#(
  parameter int SEED_W = SEED_W_DEF,
  parameter int NB_W   = NB_W_DEF,
  parameter int GAP_W  = GAP_W_DEF,
  parameter int TMO_W  = TMO_W_DEF,
  parameter int TOT_W  = TOT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [NB_W-1:0]    cfg_num_burst,
  input  logic [LEN_W-1:0]   cfg_burst_len,
  input  logic [GAP_W-1:0]   cfg_gap,
  input  logic [SEED_W-1:0]  cfg_seed,
  input  logic [SEED_W-1:0]  cfg_seed_step,
  axist_patgen_ctrl_if.master gen,
  output logic               busy,
  output logic               done,
  output logic [NB_W-1:0]    burst_idx,
  output logic [TOT_W-1:0]   beat_total,
  output logic               timeout_err,
  output logic               aborted
);
  state_t            state_q, state_d;
  logic [NB_W-1:0]   num_q, num_d, burst_idx_q, burst_idx_d;
  logic [LEN_W-1:0]  len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [SEED_W-1:0] step_q, step_d, seed_q, seed_d;
  logic [TOT_W-1:0]  beat_total_q, beat_total_d;
  logic              tmo_err_q, tmo_err_d, aborted_q, aborted_d;
  logic              gen_ena_q, gen_ena_d, busy_q, busy_d, done_q, done_d;
  logic              accept, abort_hit, beat, burst_end, last_burst, tmo_tc;

  assign accept     = (state_q == IDLE) && start;
  assign abort_hit  = abort && ((state_q == LOAD) || (state_q == RUN) || (state_q == GAP));
  assign beat       = (state_q == RUN) && gen.gen_beat;
  assign burst_end  = beat && ((beat_cnt_q + LEN_W'(1)) == len_q);
  assign last_burst = (burst_idx_q == (num_q - NB_W'(1)));

  axist_patgen_stall_tmr #(.TMO_W(TMO_W)) u_stall_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i ((state_q == LOAD) || beat),
    .inc_i ((state_q == RUN) && !gen.gen_beat),
    .tc_o  (tmo_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (cfg_num_burst != '0) ? LOAD : DONE;
      LOAD: state_d = RUN;
      RUN: begin
        if (burst_end)   state_d = last_burst ? DONE : ((gap_q == '0) ? LOAD : GAP);
        else if (tmo_tc) state_d = DONE;
      end
      GAP:  if (gap_cnt_q == GAP_W'(1)) state_d = LOAD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort outranks completion and timeout in the same cycle.
    if (abort_hit) state_d = DONE;
  end

  always_comb begin
    num_d        = num_q;
    len_d        = len_q;
    gap_d        = gap_q;
    step_d       = step_q;
    seed_d       = seed_q;
    burst_idx_d  = burst_idx_q;
    beat_total_d = beat_total_q;
    beat_cnt_d   = beat_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    tmo_err_d    = tmo_err_q;
    aborted_d    = aborted_q;
    if (accept) begin
      num_d        = cfg_num_burst;
      len_d        = (cfg_burst_len == '0) ? LEN_W'(1) : cfg_burst_len;
      gap_d        = cfg_gap;
      step_d       = cfg_seed_step;
      seed_d       = cfg_seed;
      burst_idx_d  = '0;
      beat_total_d = '0;
      tmo_err_d    = 1'b0;
      aborted_d    = 1'b0;
    end
    if (state_q == LOAD) beat_cnt_d = '0;
    if (beat) begin
      beat_cnt_d = beat_cnt_q + LEN_W'(1);
      if (beat_total_q != '1) beat_total_d = beat_total_q + TOT_W'(1);
    end
    if (burst_end && !abort_hit) begin
      seed_d = seed_q + step_q;
      if (!last_burst) burst_idx_d = burst_idx_q + NB_W'(1);
    end
    if (tmo_tc && !abort_hit) tmo_err_d = 1'b1;
    if (abort_hit) aborted_d = 1'b1;
    if (state_q == GAP)      gap_cnt_d = gap_cnt_q - GAP_W'(1);
    else if (state_d == GAP) gap_cnt_d = gap_q;
    gen_ena_d = (state_d == LOAD);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q        <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      step_q       <= '0;
      seed_q       <= '0;
      burst_idx_q  <= '0;
      beat_total_q <= '0;
      beat_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      tmo_err_q    <= 1'b0;
      aborted_q    <= 1'b0;
      gen_ena_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      num_q        <= num_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      step_q       <= step_d;
      seed_q       <= seed_d;
      burst_idx_q  <= burst_idx_d;
      beat_total_q <= beat_total_d;
      beat_cnt_q   <= beat_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      tmo_err_q    <= tmo_err_d;
      aborted_q    <= aborted_d;
      gen_ena_q    <= gen_ena_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // seed_q only moves at burst end, so it is stable and current throughout LOAD.
  assign gen.gen_ena  = gen_ena_q;
  assign gen.gen_seed = seed_q;
  assign gen.gen_cnt  = len_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign burst_idx    = burst_idx_q;
  assign beat_total   = beat_total_q;
  assign timeout_err  = tmo_err_q;
  assign aborted      = aborted_q;

endmodule

// File: tb/tb_axist_patgen_ctrl.sv
// Bench for axist_patgen_ctrl: table of run configs plus a mid-run reset sequence;
// expected generator seeds are queued at start and popped on every gen_ena.
module tb_axist_patgen_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_num_burst = '0;
  logic [8:0]  cfg_burst_len = '0;
  logic [3:0]  cfg_gap = '0;
  logic [39:0] cfg_seed = '0;
  logic [39:0] cfg_seed_step = '0;
  logic        busy, done, timeout_err, aborted;
  logic [7:0]  burst_idx;
  logic [15:0] beat_total;

  int ntest = 0;
  int nfail = 0;
  logic [39:0] exp_q[$];

  axist_patgen_ctrl_if #(.SEED_W(40)) gif ();

  axist_patgen_ctrl #(.SEED_W(40), .NB_W(8), .GAP_W(4), .TMO_W(4), .TOT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .cfg_num_burst (cfg_num_burst),
    .cfg_burst_len (cfg_burst_len),
    .cfg_gap       (cfg_gap),
    .cfg_seed      (cfg_seed),
    .cfg_seed_step (cfg_seed_step),
    .gen           (gif),
    .busy          (busy),
    .done          (done),
    .burst_idx     (burst_idx),
    .beat_total    (beat_total),
    .timeout_err   (timeout_err),
    .aborted       (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  num;
    logic [8:0]  len;
    logic [3:0]  gap;
    logic [39:0] seed;
    logic [39:0] step;
    int          mode;        // 0: gen_beat high, 1: toggling (low first in RUN), 2: held low
    int          abort_at;    // cycle index (1 = LOAD/first cycle after start) to pulse abort, 0 = none
    int          restart_at;  // cycle index to pulse start again, 0 = none
    int          exp_enas;
    int          exp_done_k;
    logic [15:0] exp_total;
    logic [7:0]  exp_idx;
    logic        exp_tmo;
    logic        exp_abt;
    logic [8:0]  exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (gif.gen_ena) begin
      if (exp_q.size() == 0) begin
        ntest++;
        nfail++;
        $display("FAIL unexpected_gen_ena: gen_seed=%0h, no burst expected", gif.gen_seed);
      end else begin
        chk("gen_seed", {24'd0, gif.gen_seed}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic run_vec(input int id, input vec_t v);
    logic [39:0] s;
    int kdone, ndone, last_ena, eff_len;
    s = v.seed;
    for (int i = 0; i < v.exp_enas; i++) begin
      exp_q.push_back(s);
      s = s + v.step;
    end
    eff_len = (v.len == 0) ? 1 : int'(v.len);
    @(negedge clk);
    cfg_num_burst = v.num;
    cfg_burst_len = v.len;
    cfg_gap       = v.gap;
    cfg_seed      = v.seed;
    cfg_seed_step = v.step;
    start         = 1'b1;
    gif.gen_beat  = (v.mode == 0);
    kdone = 0;
    ndone = 0;
    last_ena = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("v%0d_busy_on", id), busy, 1);
        chk($sformatf("v%0d_aborted_clr", id), aborted, 0);
        chk($sformatf("v%0d_tmo_clr", id), timeout_err, 0);
      end
      if (gif.gen_ena) begin
        if (last_ena >= 0 && v.mode == 0)
          chk($sformatf("v%0d_ena_spacing", id), k - last_ena, eff_len + 1 + int'(v.gap));
        last_ena = k;
      end
      if (done) begin
        ndone++;
        if (kdone == 0) kdone = k;
      end
      if (kdone != 0 && k == kdone + 1) chk($sformatf("v%0d_busy_off", id), busy, 0);
      if (kdone != 0 && k >= kdone + 2) break;
      start = (k == v.restart_at);
      abort = (k == v.abort_at);
      // Config inputs are garbage after the accepted start; only the latched copy matters.
      cfg_num_burst = 8'($urandom);
      cfg_burst_len = 9'($urandom);
      cfg_gap       = 4'($urandom);
      cfg_seed      = {8'($urandom), $urandom};
      cfg_seed_step = {8'($urandom), $urandom};
      case (v.mode)
        0:       gif.gen_beat = !abort;
        1:       gif.gen_beat = (k % 2 == 1);
        default: gif.gen_beat = 1'b0;
      endcase
    end
    start = 1'b0;
    abort = 1'b0;
    gif.gen_beat = 1'b0;
    chk($sformatf("v%0d_done_cycle", id), kdone, v.exp_done_k);
    chk($sformatf("v%0d_done_count", id), ndone, 1);
    chk($sformatf("v%0d_beat_total", id), beat_total, v.exp_total);
    chk($sformatf("v%0d_burst_idx", id), burst_idx, v.exp_idx);
    chk($sformatf("v%0d_timeout_err", id), timeout_err, v.exp_tmo);
    chk($sformatf("v%0d_aborted", id), aborted, v.exp_abt);
    chk($sformatf("v%0d_gen_cnt", id), gif.gen_cnt, v.exp_cnt);
    chk($sformatf("v%0d_seeds_left", id), exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_gen_ena"}, gif.gen_ena, 0);
    chk({tag, "_gen_seed"}, {24'd0, gif.gen_seed}, 0);
    chk({tag, "_gen_cnt"}, gif.gen_cnt, 0);
    chk({tag, "_beat_total"}, beat_total, 0);
    chk({tag, "_burst_idx"}, burst_idx, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_aborted"}, aborted, 0);
  endtask

  initial begin
    int ndone;
    //          num    len     gap   seed               step        md ab rs en dk tot    idx   tmo   abt   cnt
    vecs[0] = '{8'd0, 9'd5, 4'd0, 40'h1,             40'h1,      0, 0, 0, 0, 1, 16'd0, 8'd0, 1'b0, 1'b0, 9'd5};
    vecs[1] = '{8'd3, 9'd4, 4'd2, 40'h10,            40'h100,    0, 0, 20, 3, 20, 16'd12, 8'd2, 1'b0, 1'b0, 9'd4};
    vecs[2] = '{8'd1, 9'd8, 4'd0, 40'h123,           40'h1,      1, 0, 0, 1, 18, 16'd8, 8'd0, 1'b0, 1'b0, 9'd8};
    vecs[3] = '{8'd2, 9'd4, 4'd0, 40'h77,            40'h1,      2, 0, 0, 1, 17, 16'd0, 8'd0, 1'b1, 1'b0, 9'd4};
    vecs[4] = '{8'd4, 9'd4, 4'd1, 40'h1000,          40'h10,     0, 10, 0, 2, 11, 16'd6, 8'd1, 1'b0, 1'b1, 9'd4};
    vecs[5] = '{8'd2, 9'd0, 4'd0, 40'hFF_FFFF_FFFF,  40'h1,      0, 0, 0, 2, 5, 16'd2, 8'd1, 1'b0, 1'b0, 9'd1};
    vecs[6] = '{8'd2, 9'd3, 4'd3, 40'h5,             40'h7,      0, 0, 4, 2, 12, 16'd6, 8'd1, 1'b0, 1'b0, 9'd3};

    gif.gen_beat = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset asserted mid-GAP: outputs clear at once and the cut-off run never reports done.
    exp_q.push_back(40'hAA);
    @(negedge clk);
    cfg_num_burst = 8'd3;
    cfg_burst_len = 9'd2;
    cfg_gap       = 4'd5;
    cfg_seed      = 40'hAA;
    cfg_seed_step = 40'h11;
    start         = 1'b1;
    gif.gen_beat  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_beat_total", beat_total, 2);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    chk("rst_idle_busy", busy, 0);
    chk("rst_seeds_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
